// File: rtl/gshare_predictor.sv
// Direction predictor: table of saturating counters indexed by PC (bimodal) or PC^GHR (gshare).
// Prediction is registered with 1-cycle latency. Updates pass through two stages: U1 latches
// index/direction and shifts the GHR, U2 read-modify-writes the counter. A prediction that hits
// the index being written in U2 sees the post-update value.
module gshare_predictor #(
    parameter int unsigned TABLE_W = 10,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned GHR_W   = 10,
    parameter int unsigned PC_LSB  = 2
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_mode,
    input  logic             i_pred_valid,
    input  logic [63:0]      i_pred_pc,
    output logic             o_pred_valid,
    output logic             o_pred_taken,
    output logic [GHR_W-1:0] o_pred_ghr,
    input  logic             i_update_valid,
    input  logic [63:0]      i_update_pc,
    input  logic [GHR_W-1:0] i_update_ghr,
    input  logic             i_result_taken,
    output logic [GHR_W-1:0] o_ghr
);

    localparam int unsigned      TABLE_SIZE = 1 << TABLE_W;
    localparam logic [CNT_W-1:0] L_CNT_INIT = {1'b1, {(CNT_W - 1){1'b0}}};
    localparam logic [CNT_W-1:0] L_CNT_MAX  = '1;

    logic [CNT_W-1:0]   r_table [TABLE_SIZE];
    logic [GHR_W-1:0]   r_ghr;
    logic               r_u1_valid;
    logic [TABLE_W-1:0] r_u1_idx;
    logic               r_u1_taken;
    logic               r_pred_valid;
    logic               r_pred_taken;
    logic [GHR_W-1:0]   r_pred_ghr;

    logic [TABLE_W-1:0] w_pred_idx;
    logic [TABLE_W-1:0] w_upd_idx;
    logic [GHR_W-1:0]   w_ghr_next;
    logic [CNT_W-1:0]   w_u2_old;
    logic [CNT_W-1:0]   w_u2_new;
    logic [CNT_W-1:0]   w_pred_cnt;
    logic               w_unused;

    // PC bits outside the index window are intentionally ignored.
    assign w_unused = ^{i_pred_pc, i_update_pc};

    // Index formation: predict path hashes with the live GHR, update path with the returned one.
    always_comb begin
        w_pred_idx = i_pred_pc[PC_LSB +: TABLE_W];
        w_upd_idx  = i_update_pc[PC_LSB +: TABLE_W];
        if (i_mode) begin
            w_pred_idx = w_pred_idx ^ TABLE_W'(r_ghr);
            w_upd_idx  = w_upd_idx ^ TABLE_W'(i_update_ghr);
        end
        // Low GHR_W bits of {ghr, taken} are the shifted history.
        w_ghr_next = GHR_W'({r_ghr, i_result_taken});
    end

    // U2 saturating counter step and prediction bypass from the pending write.
    always_comb begin
        w_u2_old = r_table[r_u1_idx];
        w_u2_new = w_u2_old;
        if (r_u1_taken) begin
            if (w_u2_old != L_CNT_MAX) w_u2_new = w_u2_old + 1'b1;
        end else begin
            if (w_u2_old != '0) w_u2_new = w_u2_old - 1'b1;
        end
        w_pred_cnt = r_table[w_pred_idx];
        if (r_u1_valid && (r_u1_idx == w_pred_idx)) w_pred_cnt = w_u2_new;
    end

    // Counter table: reset to weakly taken, written once per U2.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < TABLE_SIZE; i++) r_table[i] <= L_CNT_INIT;
        end else if (r_u1_valid) begin
            r_table[r_u1_idx] <= w_u2_new;
        end
    end

    // U1 stage register and architectural GHR shift.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_u1_valid <= 1'b0;
            r_u1_idx   <= '0;
            r_u1_taken <= 1'b0;
            r_ghr      <= '0;
        end else begin
            r_u1_valid <= i_update_valid;
            if (i_update_valid) begin
                r_u1_idx   <= w_upd_idx;
                r_u1_taken <= i_result_taken;
                r_ghr      <= w_ghr_next;
            end
        end
    end

    // Registered prediction outputs; the GHR snapshot holds when idle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_ghr   <= '0;
        end else begin
            r_pred_valid <= i_pred_valid;
            r_pred_taken <= i_pred_valid & w_pred_cnt[CNT_W-1];
            if (i_pred_valid) r_pred_ghr <= r_ghr;
        end
    end

    assign o_pred_valid = r_pred_valid;
    assign o_pred_taken = r_pred_taken;
    assign o_pred_ghr   = r_pred_ghr;
    assign o_ghr        = r_ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor (TABLE_W=10, CNT_W=2, GHR_W=4, PC_LSB=2).
module tb_gshare_predictor;

    typedef struct {
        logic        mode;
        logic        uv;
        logic [63:0] upc;
        logic [3:0]  ughr;
        logic        ut;
        logic        pv;
        logic [63:0] ppc;
        logic        epv;
        logic        ept;
        logic [3:0]  epg;
        logic [3:0]  eghr;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        mode;
    logic        pred_valid;
    logic [63:0] pred_pc;
    logic        o_pred_valid;
    logic        o_pred_taken;
    logic [3:0]  o_pred_ghr;
    logic        update_valid;
    logic [63:0] update_pc;
    logic [3:0]  update_ghr;
    logic        result_taken;
    logic [3:0]  o_ghr;

    int n_checks;
    int n_fail;
    vec_t vecs[35];

    gshare_predictor #(
        .TABLE_W(10),
        .CNT_W  (2),
        .GHR_W  (4),
        .PC_LSB (2)
    ) u_dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_mode        (mode),
        .i_pred_valid  (pred_valid),
        .i_pred_pc     (pred_pc),
        .o_pred_valid  (o_pred_valid),
        .o_pred_taken  (o_pred_taken),
        .o_pred_ghr    (o_pred_ghr),
        .i_update_valid(update_valid),
        .i_update_pc   (update_pc),
        .i_update_ghr  (update_ghr),
        .i_result_taken(result_taken),
        .o_ghr         (o_ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic m, logic uv, logic [63:0] upc, logic [3:0] ughr, logic ut,
                                logic pv, logic [63:0] ppc, logic epv, logic ept,
                                logic [3:0] epg, logic [3:0] eghr);
        vec_t v;
        v.mode = m; v.uv = uv; v.upc = upc; v.ughr = ughr; v.ut = ut;
        v.pv = pv; v.ppc = ppc; v.epv = epv; v.ept = ept; v.epg = epg; v.eghr = eghr;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic epv, input logic ept,
                             input logic [3:0] epg, input logic [3:0] eghr);
        check("pred_valid", idx, {7'd0, o_pred_valid}, {7'd0, epv});
        check("pred_taken", idx, {7'd0, o_pred_taken}, {7'd0, ept});
        check("pred_ghr", idx, {4'd0, o_pred_ghr}, {4'd0, epg});
        check("ghr", idx, {4'd0, o_ghr}, {4'd0, eghr});
    endtask

    task automatic drive_idle();
        update_valid = 1'b0; update_pc = '0; update_ghr = '0; result_taken = 1'b0;
        pred_valid = 1'b0; pred_pc = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle prediction request followed by a full output check.
    task automatic predict(input int idx, input logic m, input logic [63:0] pc,
                           input logic ept, input logic [3:0] epg, input logic [3:0] eghr);
        mode = m; pred_valid = 1'b1; pred_pc = pc;
        tick();
        check_all(idx, 1'b1, ept, epg, eghr);
        drive_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Test 1 / 2: bimodal training on PC 0x1000 (index 0), saturation at both ends.
        vecs[0]  = mk(0, 0, 64'h0,    4'h0, 0, 1, 64'h1000, 1, 1, 4'h0, 4'h0);
        vecs[1]  = mk(0, 1, 64'h1000, 4'h0, 0, 0, 64'h0,    0, 0, 4'h0, 4'h0);
        vecs[2]  = mk(0, 1, 64'h1000, 4'h0, 0, 0, 64'h0,    0, 0, 4'h0, 4'h0);
        vecs[3]  = mk(0, 1, 64'h1000, 4'h0, 0, 0, 64'h0,    0, 0, 4'h0, 4'h0);
        vecs[4]  = mk(0, 0, 64'h0,    4'h0, 0, 0, 64'h0,    0, 0, 4'h0, 4'h0);
        vecs[5]  = mk(0, 0, 64'h0,    4'h0, 0, 0, 64'h0,    0, 0, 4'h0, 4'h0);
        vecs[6]  = mk(0, 0, 64'h0,    4'h0, 0, 1, 64'h1000, 1, 0, 4'h0, 4'h0);
        vecs[7]  = mk(0, 1, 64'h1000, 4'h0, 1, 0, 64'h0,    0, 0, 4'h0, 4'h1);
        vecs[8]  = mk(0, 1, 64'h1000, 4'h0, 1, 0, 64'h0,    0, 0, 4'h0, 4'h3);
        vecs[9]  = mk(0, 1, 64'h1000, 4'h0, 1, 0, 64'h0,    0, 0, 4'h0, 4'h7);
        vecs[10] = mk(0, 1, 64'h1000, 4'h0, 1, 0, 64'h0,    0, 0, 4'h0, 4'hF);
        vecs[11] = mk(0, 0, 64'h0,    4'h0, 0, 0, 64'h0,    0, 0, 4'h0, 4'hF);
        vecs[12] = mk(0, 0, 64'h0,    4'h0, 0, 1, 64'h1000, 1, 1, 4'hF, 4'hF);
        vecs[13] = mk(0, 1, 64'h1000, 4'h0, 0, 0, 64'h0,    0, 0, 4'hF, 4'hE);
        vecs[14] = mk(0, 1, 64'h1000, 4'h0, 0, 0, 64'h0,    0, 0, 4'hF, 4'hC);
        // 3 -> 2 -> 1: the 2->1 step lands in the same cycle as the request (bypass).
        vecs[15] = mk(0, 0, 64'h0,    4'h0, 0, 1, 64'h1000, 1, 0, 4'hC, 4'hC);
        // Test 3: bypass on PC 0x2010 (index 4), then floor saturation on 0x2020 (index 8).
        vecs[16] = mk(0, 1, 64'h2010, 4'h0, 0, 0, 64'h0,    0, 0, 4'hC, 4'h8);
        vecs[17] = mk(0, 0, 64'h0,    4'h0, 0, 1, 64'h2010, 1, 0, 4'h8, 4'h8);
        vecs[18] = mk(0, 1, 64'h2020, 4'h0, 0, 0, 64'h0,    0, 0, 4'h8, 4'h0);
        vecs[19] = mk(0, 1, 64'h2020, 4'h0, 0, 0, 64'h0,    0, 0, 4'h8, 4'h0);
        vecs[20] = mk(0, 1, 64'h2020, 4'h0, 0, 0, 64'h0,    0, 0, 4'h8, 4'h0);
        vecs[21] = mk(0, 0, 64'h0,    4'h0, 0, 1, 64'h2020, 1, 0, 4'h0, 4'h0);
        vecs[22] = mk(0, 1, 64'h2020, 4'h0, 1, 0, 64'h0,    0, 0, 4'h0, 4'h1);
        vecs[23] = mk(0, 0, 64'h0,    4'h0, 0, 1, 64'h2020, 1, 0, 4'h1, 4'h1);
        // Test 4: gshare history T,N,T,T -> 1011; same-cycle request sees pre-shift GHR.
        vecs[24] = mk(1, 1, 64'h100,  4'h0, 1, 0, 64'h0,    0, 0, 4'h1, 4'h3);
        vecs[25] = mk(1, 1, 64'h100,  4'h0, 0, 0, 64'h0,    0, 0, 4'h1, 4'h6);
        vecs[26] = mk(1, 1, 64'h100,  4'h0, 1, 0, 64'h0,    0, 0, 4'h1, 4'hD);
        vecs[27] = mk(1, 1, 64'h100,  4'h0, 1, 1, 64'h0,    1, 1, 4'hD, 4'hB);
        vecs[28] = mk(1, 0, 64'h0,    4'h0, 0, 1, 64'h0,    1, 1, 4'hB, 4'hB);
        // Test 5: train gshare index 0xB, read it as PC 0x1C (pcidx 7) ^ GHR 0xC, flip modes.
        vecs[29] = mk(1, 1, 64'h0,    4'hB, 0, 0, 64'h0,    0, 0, 4'hB, 4'h6);
        vecs[30] = mk(1, 1, 64'h0,    4'hB, 0, 0, 64'h0,    0, 0, 4'hB, 4'hC);
        vecs[31] = mk(1, 0, 64'h0,    4'h0, 0, 0, 64'h0,    0, 0, 4'hB, 4'hC);
        vecs[32] = mk(1, 0, 64'h0,    4'h0, 0, 1, 64'h1C,   1, 0, 4'hC, 4'hC);
        vecs[33] = mk(0, 0, 64'h0,    4'h0, 0, 1, 64'h1C,   1, 1, 4'hC, 4'hC);
        vecs[34] = mk(1, 0, 64'h0,    4'h0, 0, 1, 64'h1C,   1, 0, 4'hC, 4'hC);

        reset_n = 1'b0;
        mode = 1'b0;
        drive_idle();
        tick();
        tick();
        check_all(-1, 1'b0, 1'b0, 4'h0, 4'h0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            mode         = vecs[i].mode;
            update_valid = vecs[i].uv;
            update_pc    = vecs[i].upc;
            update_ghr   = vecs[i].ughr;
            result_taken = vecs[i].ut;
            pred_valid   = vecs[i].pv;
            pred_pc      = vecs[i].ppc;
            tick();
            check_all(i, vecs[i].epv, vecs[i].ept, vecs[i].epg, vecs[i].eghr);
        end
        drive_idle();

        // Test 6: reset asserted mid-cycle with an update in U1 and a live prediction.
        mode = 1'b0;
        update_valid = 1'b1; update_pc = 64'h2010; result_taken = 1'b0;
        pred_valid = 1'b1; pred_pc = 64'h2010;
        tick();
        check_all(100, 1'b1, 1'b0, 4'hC, 4'h8);
        drive_idle();
        #2;
        reset_n = 1'b0;
        #1;
        check_all(101, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check_all(102, 1'b0, 1'b0, 4'h0, 4'h0);
        // Counters previously trained down must be weakly taken again.
        predict(103, 1'b0, 64'h2010, 1'b1, 4'h0, 4'h0);
        predict(104, 1'b0, 64'h2020, 1'b1, 4'h0, 4'h0);
        predict(105, 1'b0, 64'h2C, 1'b1, 4'h0, 4'h0);
        predict(106, 1'b1, 64'h0, 1'b1, 4'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
